dma_copy_engine: RTL

Word-copy DMA engine sitting downstream of the CPU control block. The control block issues a copy command when it executes CPY: source, destination and length. The engine then moves that many 32-bit words through the shared single-port SRAM, one read followed by one write per word. The CPU always has priority on the SRAM port, and the engine reports `busy` for the POL instruction.

---
 rtl/dma_copy_engine_pkg.sv | 15 +
 rtl/dma_copy_engine.sv | 122 ++++++++++++
 2 files changed

// File: rtl/dma_copy_engine_pkg.sv
// dma_copy_engine_pkg
//   Shared definitions for the word-copy DMA engine.
//   - dma_state_e : 3-bit FSM state encoding, also used for debug visibility
//                   by the control block and the port-mux wrapper.
package dma_copy_engine_pkg;

    typedef enum logic [2:0] {
        DMA_STATE_IDLE    = 3'd0,
        DMA_STATE_RD      = 3'd1,
        DMA_STATE_RD_DATA = 3'd2,
        DMA_STATE_WR      = 3'd3,
        DMA_STATE_DONE    = 3'd4
    } dma_state_e;

endpackage

// File: rtl/dma_copy_engine.sv
// dma_copy_engine
//   Word-copy DMA. Moves cmd_len 32-bit words from cmd_src to cmd_dst through
//   the shared single-port SRAM, one read then one write per word. The CPU has
//   priority on the port: whenever mem_busy is high the engine leaves the port
//   alone and waits in place.
//
// Ports
//   clk        : single clock
//   reset      : synchronous, active-low
//   cmd_*      : copy command (valid/ready, source, destination, word count)
//   mem_busy   : CPU owns the SRAM port this cycle
//   sram_DO    : SRAM read data, one cycle after the read strobe
//   sram_ADDR/sram_DI/sram_EN/sram_WE : DMA side of the SRAM port
//   dma_own    : selects the DMA side at the external port mux
//   busy       : copy in progress
//   done       : one-cycle pulse when a copy completes
//
// State table
//   state             | meaning
//   DMA_STATE_IDLE    | waiting for a command, cmd_ready high
//   DMA_STATE_RD      | issue read of src (waits while mem_busy)
//   DMA_STATE_RD_DATA | capture sram_DO into the data register
//   DMA_STATE_WR      | issue write of data to dst (waits while mem_busy)
//   DMA_STATE_DONE    | one-cycle completion pulse
module dma_copy_engine
    import dma_copy_engine_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              mem_busy,
    input  logic [DATA_W-1:0] sram_DO,
    output logic [ADDR_W-1:0] sram_ADDR,
    output logic [DATA_W-1:0] sram_DI,
    output logic              sram_EN,
    output logic              sram_WE,
    output logic              dma_own,
    output logic              busy,
    output logic              done
);

    dma_state_e        state;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] data;

    logic drive_rd;
    logic drive_wr;

    // len counts down the words still to write; the terminal compare against 1
    // happens on the write that consumes the last word, so len never reaches 0
    // inside WR.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= DMA_STATE_IDLE;
            src   <= '0;
            dst   <= '0;
            len   <= '0;
            data  <= '0;
        end else begin
            case (state)
                DMA_STATE_IDLE: begin
                    if (cmd_valid) begin
                        src   <= cmd_src;
                        dst   <= cmd_dst;
                        len   <= cmd_len;
                        state <= (cmd_len == '0) ? DMA_STATE_DONE : DMA_STATE_RD;
                    end
                end
                DMA_STATE_RD: begin
                    if (!mem_busy) begin
                        state <= DMA_STATE_RD_DATA;
                    end
                end
                DMA_STATE_RD_DATA: begin
                    // Read was already issued; mem_busy cannot retract it.
                    data  <= sram_DO;
                    state <= DMA_STATE_WR;
                end
                DMA_STATE_WR: begin
                    if (!mem_busy) begin
                        src   <= src + ADDR_W'(1);
                        dst   <= dst + ADDR_W'(1);
                        len   <= len - LEN_W'(1);
                        state <= (len == LEN_W'(1)) ? DMA_STATE_DONE : DMA_STATE_RD;
                    end
                end
                DMA_STATE_DONE: begin
                    state <= DMA_STATE_IDLE;
                end
                default: begin
                    state <= DMA_STATE_IDLE;
                end
            endcase
        end
    end

    // Port outputs follow state and mem_busy directly so the engine can never
    // collide with a CPU access in the same cycle.
    assign drive_rd = (state == DMA_STATE_RD) && !mem_busy;
    assign drive_wr = (state == DMA_STATE_WR) && !mem_busy;

    assign sram_EN   = drive_rd | drive_wr;
    assign sram_WE   = drive_wr;
    assign sram_ADDR = drive_rd ? src : (drive_wr ? dst : '0);
    assign sram_DI   = drive_wr ? data : '0;
    assign dma_own   = drive_rd | drive_wr;

    assign busy      = (state != DMA_STATE_IDLE);
    assign done      = (state == DMA_STATE_DONE);
    assign cmd_ready = (state == DMA_STATE_IDLE) & reset;

endmodule
